chip8_mem_seq: RTL and testbench
================================

# chip8_mem_seq

Parametrised multi-cycle memory sequencer for the CHIP-8 core. It executes the bulk register/memory opcodes that the single-cycle decode path cannot handle: Fx33 (BCD store), Fx55 (store V0..Vx) and Fx65 (load V0..Vx). It sits between the CPU decode stage, the CPU register file and the shared memory port. Register count and address width are generic, so the block can also serve extended (SCHIP-style) cores.

## Interface
Parameters:
- ADDR_W, 12: memory address width. All address arithmetic wraps modulo 2^ADDR_W.
- NUM_REGS, 16: register file depth, at least 2. REG_AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0 = BCD, 1 = STORE, 2 = LOAD, 3 = reserved (accepted, completes as no-op)
- cmd_x  in  4  last register index
- cmd_vx  in  8  Vx value (BCD only)
- cmd_i  in  ADDR_W  base address (I register)
- reg_rd_addr  out  REG_AW  register file read index; read data is combinational
- reg_rd_data  in  8  register file read data
- reg_wr_en / reg_wr_addr / reg_wr_data  out  1 / REG_AW / 8  register write port
- mem_read / mem_read_addr  out  1 / ADDR_W  read request
- mem_read_data / mem_read_ack  in  8 / 1  data valid in the ack cycle
- mem_write / mem_write_addr / mem_write_data  out  1 / ADDR_W / 8  single-cycle write pulse, no ack
- done  out  1  one-cycle completion pulse
- i_wr_en / i_wr_data  out  1 / ADDR_W  I register update

## Operation
- States: IDLE, BCD, STORE, LD_REQ, LD_WB, DONE.
- Accept a command when cmd_valid && cmd_ready. Latch op, cmd_i, cmd_vx and n = min(cmd_x, NUM_REGS-1). Clear counter k.
- BCD: emit 3 consecutive write cycles:
  - I gets vx/100
  - I+1 gets (vx/10)%10
  - I+2 gets vx%10
- STORE: for k = 0..n, one write per cycle. reg_rd_addr = k, mem_write_addr = I+k, mem_write_data = reg_rd_data.
- LOAD, per k:
  - LD_REQ: hold mem_read=1 with addr I+k until mem_read_ack. Capture data and drop mem_read in the following cycle.
  - LD_WB: reg_wr_en=1, reg_wr_addr=k, reg_wr_data=captured byte.
  - If k==n go to DONE, else k+1 and return to LD_REQ.
- DONE: pulse done for one cycle, then go to IDLE.
- A mem_read_ack outside LD_REQ is ignored.
- cmd_valid while busy is ignored; the requester holds it.
- Address wrap: I+k computed in ADDR_W bits, so 0xFFF+1 = 0x000.

## Timing
- Reset values: cmd_ready=1. All other outputs 0, including every address and data output.
- Reset mid-operation aborts immediately. No further writes; state returns to IDLE.
- BCD latency is 5 cycles from the accept edge: writes in cycles 1-3, done in cycle 4, ready in cycle 5.
- STORE latency: n+1 write cycles, then done, then ready.
- LOAD latency: sum over bytes of (ack latency + 1 writeback), then done.
- mem_write never overlaps mem_read.
- cmd_ready is 0 in every non-IDLE cycle.

## Configuration
- CHIP8_I_INCR_EN defined:
  - In the done cycle, i_wr_en=1 and i_wr_data = I+n+1 (wrapped) for STORE and LOAD.
  - BCD and reserved ops leave i_wr_en=0.
- Undefined: i_wr_en is tied 0 and I is unchanged (modern quirk).

## Structure
- Package chip8_pkg holds:
  - the cmd_op encoding constants (OP_BCD, OP_STORE, OP_LOAD)
  - the state enum
  - the default ADDR_W and NUM_REGS
- Sub-module chip8_bcd: a combinational 8-bit to 3-digit converter using shift-add-3. No divider is inferred.

## Test plan
- BCD, vx=254, I=0x300: writes 0x300=2, 0x301=5, 0x302=4 on consecutive cycles; done 1 cycle later; i_wr_en=0.
- STORE, x=3, V0..V3=0x11,0x22,0x33,0x44, I=0x400: 4 consecutive writes to 0x400..0x403; done; with macro, i_wr_data=0x404.
- LOAD, x=15, memory ack latency 2, I=0x500 holding 0x00..0x0F: 16 reg writes Vk=k; mem_read is never high during a write.
- Wrap: STORE x=2 at I=0xFFE writes to 0xFFE, 0xFFF, 0x000; with macro, i_wr_data=0x001.
- Clamp: NUM_REGS=8 with cmd_x=12 stores exactly 8 bytes.
- Abort: assert rst_n low during the 3rd LOAD byte: all outputs 0 asynchronously; no further reg/mem writes; after release cmd_ready=1 and a new BCD completes normally.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory sequencer: op encodings, FSM states, default sizes.
// Ports: none (package only).
// Imported by chip8_mem_seq_if, chip8_mem_seq and the bench.
package chip8_pkg;

   localparam int DEF_ADDR_W   = 12;
   localparam int DEF_NUM_REGS = 16;

   localparam logic [1:0] OP_BCD   = 2'd0;
   localparam logic [1:0] OP_STORE = 2'd1;
   localparam logic [1:0] OP_LOAD  = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BCD,
      ST_STORE,
      ST_LD_REQ,
      ST_LD_WB,
      ST_DONE
   } state_e;

endpackage

// File: rtl/chip8_mem_seq_if.sv
// Bundle of command, register-file, memory-port and completion signals around the sequencer.
// master: sequencer side (accepts commands, drives reg/mem requests, done, I update).
// slave: environment side (decode stage, register file, memory).
interface chip8_mem_seq_if #(
   parameter int ADDR_W   = chip8_pkg::DEF_ADDR_W,
   parameter int NUM_REGS = chip8_pkg::DEF_NUM_REGS
);
   localparam int REG_AW = $clog2(NUM_REGS);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [3:0]        cmd_x;
   logic [7:0]        cmd_vx;
   logic [ADDR_W-1:0] cmd_i;

   logic [REG_AW-1:0] reg_rd_addr;
   logic [7:0]        reg_rd_data;
   logic              reg_wr_en;
   logic [REG_AW-1:0] reg_wr_addr;
   logic [7:0]        reg_wr_data;

   logic              mem_read;
   logic [ADDR_W-1:0] mem_read_addr;
   logic [7:0]        mem_read_data;
   logic              mem_read_ack;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_write_addr;
   logic [7:0]        mem_write_data;

   logic              done;
   logic              i_wr_en;
   logic [ADDR_W-1:0] i_wr_data;

   modport master (
      input  cmd_valid, cmd_op, cmd_x, cmd_vx, cmd_i,
      input  reg_rd_data, mem_read_data, mem_read_ack,
      output cmd_ready, reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
      output mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
      output done, i_wr_en, i_wr_data
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_x, cmd_vx, cmd_i,
      output reg_rd_data, mem_read_data, mem_read_ack,
      input  cmd_ready, reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
      input  mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
      input  done, i_wr_en, i_wr_data
   );

endinterface

// File: rtl/chip8_bcd.sv
// Combinational 8-bit binary to 3-digit BCD converter (shift-add-3, no divider).
// Ports: bin in 8; hund/tens/ones out 4 each.
// Latency: purely combinational; no handshake.
module chip8_bcd (
   input  logic [7:0] bin,
   output logic [3:0] hund,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   // [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary being shifted in
   logic [19:0] scratch;

   always_comb begin
      scratch = {12'd0, bin};
      for (int b = 0; b < 8; b++) begin
         // Pre-correct any digit >= 5 so the following shift carries into the next decade
         if (scratch[11:8]  >= 4'd5) scratch[11:8]  = scratch[11:8]  + 4'd3;
         if (scratch[15:12] >= 4'd5) scratch[15:12] = scratch[15:12] + 4'd3;
         if (scratch[19:16] >= 4'd5) scratch[19:16] = scratch[19:16] + 4'd3;
         scratch = scratch << 1;
      end
      hund = scratch[19:16];
      tens = scratch[15:12];
      ones = scratch[11:8];
   end

endmodule

// File: rtl/chip8_mem_seq.sv
// Multi-cycle sequencer for Fx33 (BCD), Fx55 (store V0..Vx) and Fx65 (load V0..Vx).
// Latency: BCD 3 writes + done; STORE n+1 writes + done; LOAD per byte (ack wait + 1 writeback) + done.
// Backpressure: cmd_ready only in IDLE; memory reads held until mem_read_ack; writes are fire-and-forget.
// Ports: clk, rst_n (async active-low), bus (chip8_mem_seq_if.master).
// Optional feature macro CHIP8_I_INCR_EN: update I to I+n+1 in the done cycle of STORE/LOAD.
module chip8_mem_seq
   import chip8_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic           clk,
   input  logic           rst_n,
   chip8_mem_seq_if.master bus
);

   localparam int REG_AW = $clog2(NUM_REGS);
   // Counter must reach 2 for BCD even when the register file is tiny
   localparam int KW = (REG_AW < 2) ? 2 : REG_AW;
   localparam logic [KW-1:0] N_MAX = KW'(NUM_REGS - 1);

   state_e            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] i_q, i_d;
   logic [7:0]        vx_q, vx_d;
   logic [KW-1:0]     n_q, n_d;
   logic [KW-1:0]     k_q, k_d;
   logic [7:0]        rdat_q, rdat_d;

   logic [3:0]        bcd_hund, bcd_tens, bcd_ones;
   logic [ADDR_W-1:0] addr_k;

   logic              cmd_ready_c;
   logic [REG_AW-1:0] reg_rd_addr_c;
   logic              reg_wr_en_c;
   logic [REG_AW-1:0] reg_wr_addr_c;
   logic [7:0]        reg_wr_data_c;
   logic              mem_read_c;
   logic [ADDR_W-1:0] mem_read_addr_c;
   logic              mem_write_c;
   logic [ADDR_W-1:0] mem_write_addr_c;
   logic [7:0]        mem_write_data_c;
   logic              done_c;
   logic              i_wr_en_c;
   logic [ADDR_W-1:0] i_wr_data_c;

   chip8_bcd u_bcd (
      .bin  (vx_q),
      .hund (bcd_hund),
      .tens (bcd_tens),
      .ones (bcd_ones)
   );

   // Wraps naturally at ADDR_W bits
   assign addr_k = i_q + ADDR_W'(k_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         i_q     <= '0;
         vx_q    <= '0;
         n_q     <= '0;
         k_q     <= '0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         i_q     <= i_d;
         vx_q    <= vx_d;
         n_q     <= n_d;
         k_q     <= k_d;
         rdat_q  <= rdat_d;
      end
   end

   // Outputs are decoded from state only, so an async reset zeroes them immediately
   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      i_d              = i_q;
      vx_d             = vx_q;
      n_d              = n_q;
      k_d              = k_q;
      rdat_d           = rdat_q;
      cmd_ready_c      = 1'b0;
      reg_rd_addr_c    = '0;
      reg_wr_en_c      = 1'b0;
      reg_wr_addr_c    = '0;
      reg_wr_data_c    = '0;
      mem_read_c       = 1'b0;
      mem_read_addr_c  = '0;
      mem_write_c      = 1'b0;
      mem_write_addr_c = '0;
      mem_write_data_c = '0;
      done_c           = 1'b0;
      i_wr_en_c        = 1'b0;
      i_wr_data_c      = '0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready_c = 1'b1;
            if (bus.cmd_valid) begin
               op_d = bus.cmd_op;
               i_d  = bus.cmd_i;
               vx_d = bus.cmd_vx;
               // Clamp the last index to the physical register file
               n_d  = (int'(bus.cmd_x) > NUM_REGS - 1) ? N_MAX : KW'(bus.cmd_x);
               k_d  = '0;
               case (bus.cmd_op)
                  OP_BCD:   state_d = ST_BCD;
                  OP_STORE: state_d = ST_STORE;
                  OP_LOAD:  state_d = ST_LD_REQ;
                  default:  state_d = ST_DONE;
               endcase
            end
         end

         ST_BCD: begin
            mem_write_c      = 1'b1;
            mem_write_addr_c = addr_k;
            if (k_q == KW'(0))      mem_write_data_c = {4'd0, bcd_hund};
            else if (k_q == KW'(1)) mem_write_data_c = {4'd0, bcd_tens};
            else                    mem_write_data_c = {4'd0, bcd_ones};
            if (k_q == KW'(2)) state_d = ST_DONE;
            else               k_d     = k_q + KW'(1);
         end

         ST_STORE: begin
            reg_rd_addr_c    = k_q[REG_AW-1:0];
            mem_write_c      = 1'b1;
            mem_write_addr_c = addr_k;
            mem_write_data_c = bus.reg_rd_data;
            if (k_q == n_q) state_d = ST_DONE;
            else            k_d     = k_q + KW'(1);
         end

         ST_LD_REQ: begin
            mem_read_c      = 1'b1;
            mem_read_addr_c = addr_k;
            if (bus.mem_read_ack) begin
               rdat_d  = bus.mem_read_data;
               state_d = ST_LD_WB;
            end
         end

         ST_LD_WB: begin
            reg_wr_en_c   = 1'b1;
            reg_wr_addr_c = k_q[REG_AW-1:0];
            reg_wr_data_c = rdat_q;
            if (k_q == n_q) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + KW'(1);
               state_d = ST_LD_REQ;
            end
         end

         ST_DONE: begin
            done_c  = 1'b1;
`ifdef CHIP8_I_INCR_EN
            if (op_q == OP_STORE || op_q == OP_LOAD) begin
               i_wr_en_c   = 1'b1;
               i_wr_data_c = i_q + ADDR_W'(n_q) + ADDR_W'(1);
            end
`else
            // Modern behaviour: I is left untouched
            i_wr_en_c = 1'b0;
`endif
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.cmd_ready      = cmd_ready_c;
   assign bus.reg_rd_addr    = reg_rd_addr_c;
   assign bus.reg_wr_en      = reg_wr_en_c;
   assign bus.reg_wr_addr    = reg_wr_addr_c;
   assign bus.reg_wr_data    = reg_wr_data_c;
   assign bus.mem_read       = mem_read_c;
   assign bus.mem_read_addr  = mem_read_addr_c;
   assign bus.mem_write      = mem_write_c;
   assign bus.mem_write_addr = mem_write_addr_c;
   assign bus.mem_write_data = mem_write_data_c;
   assign bus.done           = done_c;
   assign bus.i_wr_en        = i_wr_en_c;
   assign bus.i_wr_data      = i_wr_data_c;

endmodule

// File: tb/tb_chip8_mem_seq.sv
// Bench for chip8_mem_seq: scoreboard of expected writes/done events with cycle stamps.
// Second instance with NUM_REGS=8 exercises index clamping.
// Honours CHIP8_I_INCR_EN when computing expected I updates.
module tb_chip8_mem_seq;
   import chip8_pkg::*;

`ifdef CHIP8_I_INCR_EN
   localparam bit INCR = 1'b1;
`else
   localparam bit INCR = 1'b0;
`endif
   localparam int LAT = 2;

   typedef struct {
      int kind;   // 0 mem write, 1 reg write, 2 done (addr=i_wr_en, data=i_wr_data)
      int addr;
      int data;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chip8_mem_seq_if #(.ADDR_W(12), .NUM_REGS(16)) bus ();
   chip8_mem_seq_if #(.ADDR_W(12), .NUM_REGS(8))  b8 ();

   chip8_mem_seq #(.ADDR_W(12), .NUM_REGS(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   chip8_mem_seq #(.ADDR_W(12), .NUM_REGS(8))  u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   rd_cnt = 0;
   exp_t sb[$];
   logic [7:0] regs [16];
   logic [7:0] mem  [4096];

   int   w8_cnt = 0;
   int   w8_last_addr = 0;
   int   w8_last_data = 0;
   int   d8_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int addr, input int data, input int c);
      exp_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
      sb.push_back(e);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   assign bus.reg_rd_data = regs[bus.reg_rd_addr];
   assign b8.reg_rd_data  = 8'h60 + 8'(b8.reg_rd_addr);
   assign b8.mem_read_data = 8'h00;
   assign b8.mem_read_ack  = 1'b0;

   // Memory with fixed ack latency plus register-file write model
   always @(negedge clk) begin
      if (bus.mem_read) begin
         rd_cnt++;
         if (rd_cnt >= LAT) begin
            bus.mem_read_ack  = 1'b1;
            bus.mem_read_data = mem[bus.mem_read_addr];
         end else begin
            bus.mem_read_ack  = 1'b0;
         end
      end else begin
         rd_cnt            = 0;
         bus.mem_read_ack  = 1'b0;
         bus.mem_read_data = 8'h00;
      end
      if (bus.mem_write) mem[bus.mem_write_addr] = bus.mem_write_data;
      if (bus.reg_wr_en) regs[bus.reg_wr_addr] = bus.reg_wr_data;
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      int   kind;
      if (bus.mem_write || bus.reg_wr_en || bus.done) begin
         chk("busy_ready", bus.cmd_ready, 0);
         if (bus.mem_write || bus.reg_wr_en) chk("no_read_during_write", bus.mem_read, 0);
         if (sb.size() == 0) begin
            chk("unexpected_evt", sb.size(), 1);
         end else begin
            e    = sb.pop_front();
            kind = bus.mem_write ? 0 : (bus.reg_wr_en ? 1 : 2);
            chk("evt_kind", kind, e.kind);
            chk("evt_cycle", cyc, e.cyc);
            if (kind == 0) begin
               chk("mem_wr_addr", bus.mem_write_addr, e.addr);
               chk("mem_wr_data", bus.mem_write_data, e.data);
            end else if (kind == 1) begin
               chk("reg_wr_addr", bus.reg_wr_addr, e.addr);
               chk("reg_wr_data", bus.reg_wr_data, e.data);
            end else begin
               chk("i_wr_en", bus.i_wr_en, e.addr);
               chk("i_wr_data", bus.i_wr_data, e.data);
            end
         end
      end
      if (bus.done) done_cnt++;
   end

   always @(negedge clk) begin
      if (b8.mem_write) begin
         w8_cnt++;
         w8_last_addr = b8.mem_write_addr;
         w8_last_data = b8.mem_write_data;
      end
      if (b8.done) d8_cnt++;
   end

   task automatic chk_idle(input string p);
      chk({p, "_cmd_ready"}, bus.cmd_ready, 1);
      chk({p, "_mem_read"}, bus.mem_read, 0);
      chk({p, "_mem_read_addr"}, bus.mem_read_addr, 0);
      chk({p, "_mem_write"}, bus.mem_write, 0);
      chk({p, "_mem_write_addr"}, bus.mem_write_addr, 0);
      chk({p, "_mem_write_data"}, bus.mem_write_data, 0);
      chk({p, "_reg_wr_en"}, bus.reg_wr_en, 0);
      chk({p, "_reg_wr_addr"}, bus.reg_wr_addr, 0);
      chk({p, "_reg_wr_data"}, bus.reg_wr_data, 0);
      chk({p, "_reg_rd_addr"}, bus.reg_rd_addr, 0);
      chk({p, "_done"}, bus.done, 0);
      chk({p, "_i_wr_en"}, bus.i_wr_en, 0);
      chk({p, "_i_wr_data"}, bus.i_wr_data, 0);
   endtask

   // Drive one command; returns the cycle value seen by the monitor in the first busy cycle
   task automatic issue(input logic [1:0] op, input logic [3:0] x, input logic [7:0] vx,
                        input logic [11:0] i, output int a);
      @(negedge clk);
      chk("ready_before_accept", bus.cmd_ready, 1);
      bus.cmd_op    = op;
      bus.cmd_x     = x;
      bus.cmd_vx    = vx;
      bus.cmd_i     = i;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      a = cyc;
   endtask

   task automatic wait_done(input int n0, input int bound);
      for (int t = 0; t < bound; t++) begin
         @(negedge clk);
         #1;
         if (done_cnt != n0) break;
      end
      chk("done_seen", done_cnt, n0 + 1);
      @(negedge clk);
      chk("ready_after_done", bus.cmd_ready, 1);
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic run_bcd(input int vx, input int i);
      int a, n0;
      n0 = done_cnt;
      issue(OP_BCD, 4'd0, 8'(vx), 12'(i), a);
      push(0, (i    ) & 12'hFFF, vx / 100,       a);
      push(0, (i + 1) & 12'hFFF, (vx / 10) % 10, a + 1);
      push(0, (i + 2) & 12'hFFF, vx % 10,        a + 2);
      push(2, 0, 0, a + 3);
      wait_done(n0, 20);
   endtask

   task automatic run_store(input int x, input int i);
      int a, n0, n;
      n0 = done_cnt;
      n  = (x > 15) ? 15 : x;
      issue(OP_STORE, 4'(x), 8'h00, 12'(i), a);
      for (int k = 0; k <= n; k++) push(0, (i + k) & 12'hFFF, regs[k], a + k);
      push(2, INCR ? 1 : 0, INCR ? ((i + n + 1) & 12'hFFF) : 0, a + n + 1);
      wait_done(n0, 40);
   endtask

   task automatic run_load(input int x, input int i);
      int a, n0;
      n0 = done_cnt;
      issue(OP_LOAD, 4'(x), 8'h00, 12'(i), a);
      for (int k = 0; k <= x; k++) push(1, k, mem[(i + k) & 12'hFFF], a + (LAT + 1) * k + LAT);
      push(2, INCR ? 1 : 0, INCR ? ((i + x + 1) & 12'hFFF) : 0, a + (LAT + 1) * (x + 1));
      wait_done(n0, 200);
   endtask

   initial begin
      int a, n0;
      int bv [6] = '{254, 0, 9, 100, 199, 255};
      int bi [6] = '{12'h300, 12'h310, 12'h320, 12'h330, 12'h340, 12'hFFE};

      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_x = 4'd0; bus.cmd_vx = 8'd0; bus.cmd_i = 12'd0;
      b8.cmd_valid  = 1'b0; b8.cmd_op  = 2'd0; b8.cmd_x  = 4'd0; b8.cmd_vx  = 8'd0; b8.cmd_i  = 12'd0;
      for (int k = 0; k < 16; k++) regs[k] = 8'h00;
      for (int m = 0; m < 4096; m++) mem[m] = 8'h00;

      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // BCD, including the 254 @ 0x300 case and a wrap past 0xFFF
      for (int j = 0; j < 6; j++) run_bcd(bv[j], bi[j]);

      // STORE x=3 at 0x400
      regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
      run_store(3, 12'h400);

      // LOAD x=15 from 0x500 holding 0x00..0x0F
      for (int k = 0; k < 16; k++) mem[12'h500 + k] = 8'(k);
      run_load(15, 12'h500);
      for (int k = 0; k < 16; k++) chk("load_reg_val", regs[k], k);

      // STORE wrap at 0xFFE
      regs[0] = 8'hA0; regs[1] = 8'hA1; regs[2] = 8'hA2;
      run_store(2, 12'hFFE);
      chk("wrap_mem_000", mem[0], 8'hA2);

      // Reserved op completes immediately as a no-op
      n0 = done_cnt;
      issue(OP_RSVD, 4'd5, 8'h00, 12'h600, a);
      push(2, 0, 0, a);
      wait_done(n0, 10);

      // Clamp on the 8-register instance
      @(negedge clk);
      b8.cmd_op = OP_STORE; b8.cmd_x = 4'd12; b8.cmd_i = 12'h200; b8.cmd_valid = 1'b1;
      @(posedge clk);
      #1 b8.cmd_valid = 1'b0;
      for (int t = 0; t < 40 && d8_cnt == 0; t++) @(negedge clk);
      @(negedge clk);
      chk("clamp_done", d8_cnt, 1);
      chk("clamp_write_cnt", w8_cnt, 8);
      chk("clamp_last_addr", w8_last_addr, 12'h207);
      chk("clamp_last_data", w8_last_data, 8'h67);
      chk("clamp_ready", b8.cmd_ready, 1);

      // Abort during the 3rd LOAD byte
      for (int k = 0; k < 16; k++) mem[12'h700 + k] = 8'hC0 + 8'(k);
      issue(OP_LOAD, 4'd15, 8'h00, 12'h700, a);
      push(1, 0, 8'hC0, a + LAT);
      push(1, 1, 8'hC1, a + (LAT + 1) + LAT);
      repeat (3 * (LAT + 1) - 2) @(negedge clk);
      @(negedge clk);
      chk("abort_in_ld_req", bus.mem_read, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("abort");
      chk("abort_sb_empty", sb.size(), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_abort_ready", bus.cmd_ready, 1);
      run_bcd(137, 12'h123);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
